// File: rtl/kij_load_scheduler_if.sv
// Control bundle between kij_load_scheduler and the SRAMs / core.
// master = scheduler side, slave = environment side.
interface kij_load_scheduler_if #(
  parameter int aw = 11
);
  logic          start;
  logic          iter_done;
  logic          cenw;
  logic          ceni;
  logic          w_x;
  logic [aw-1:0] Aw;
  logic [aw-1:0] Ai;
  logic          core_rst;
  logic [3:0]    kij;
  logic          psum_rd;
  logic [aw-1:0] psum_addr;
  logic          busy;
  logic          done;

  modport master (
    input  start,
    input  iter_done,
    output cenw,
    output ceni,
    output w_x,
    output Aw,
    output Ai,
    output core_rst,
    output kij,
    output psum_rd,
    output psum_addr,
    output busy,
    output done
  );

  modport slave (
    output start,
    output iter_done,
    input  cenw,
    input  ceni,
    input  w_x,
    input  Aw,
    input  Ai,
    input  core_rst,
    input  kij,
    input  psum_rd,
    input  psum_addr,
    input  busy,
    input  done
  );
endinterface

// File: rtl/kij_load_scheduler.sv
// Per-kij weight/activation load sequencer for the 3x3 conv core.
// Define KIJ_PSUM_READOUT_EN to add the psum-memory DRAIN readout.
module kij_load_scheduler #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int num_inp = 64,
  parameter int kij_len = 9,
  parameter int aw      = 11
) (
  input logic                  clk,
  input logic                  reset,
  kij_load_scheduler_if.master bus
);

  if (kij_len * row > (1 << aw) || col < 1
      || kij_len > 16 || num_inp < 1) begin : g_bad_cfg
    $error("kij_load_scheduler: unsupported geometry");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_A,
    S_WAIT_IT,
    S_CRST,
`ifdef KIJ_PSUM_READOUT_EN
    S_DRAIN,
`endif
    S_DONE
  } state_e;

  localparam logic [aw-1:0] ONE      = aw'(1);
  localparam logic [aw-1:0] ROW_LAST = aw'(row - 1);
  localparam logic [aw-1:0] INP_LAST = aw'(num_inp - 1);
  localparam logic [3:0]    KIJ_LAST = 4'(kij_len - 1);

  state_e        state_q, state_d;
  logic [aw-1:0] cnt_q, cnt_d;
  logic [3:0]    kcnt_q, kcnt_d;
  logic [aw-1:0] ptr_q, ptr_d;
  logic          flag_q, flag_d;

  logic          cenw_q, cenw_d;
  logic          ceni_q, ceni_d;
  logic          wx_q, wx_d;
  logic [aw-1:0] waddr_q, waddr_d;
  logic [aw-1:0] iaddr_q, iaddr_d;
  logic          crst_q, crst_d;
  logic [3:0]    kij_q, kij_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef KIJ_PSUM_READOUT_EN
  logic          prd_q, prd_d;
  logic [aw-1:0] paddr_q, paddr_d;
`endif

  logic iter_live;
  assign iter_live = (state_q == S_LOAD_W)
                  || (state_q == S_LOAD_A)
                  || (state_q == S_WAIT_IT);

  // Outputs are decoded from the current state and registered,
  // so every output trails the state register by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kcnt_d  = kcnt_q;
    ptr_d   = ptr_q;
    flag_d  = flag_q;
    cenw_d  = (state_q != S_LOAD_W);
    ceni_d  = (state_q != S_LOAD_A);
    wx_d    = (state_q == S_LOAD_W);
    waddr_d = waddr_q;
    iaddr_d = '0;
    crst_d  = (state_q == S_CRST);
    kij_d   = kcnt_q;
    busy_d  = (state_q != S_IDLE);
    done_d  = (state_q == S_DONE);
`ifdef KIJ_PSUM_READOUT_EN
    prd_d   = 1'b0;
    paddr_d = paddr_q;
`endif

    if (bus.iter_done && iter_live) begin
      flag_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        kcnt_d  = '0;
        ptr_d   = '0;
        flag_d  = 1'b0;
        waddr_d = '0;
`ifdef KIJ_PSUM_READOUT_EN
        paddr_d = '0;
`endif
        if (bus.start) begin
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        waddr_d = ptr_q;
        if (cnt_q == ROW_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD_A;
          // hold at the final weight word instead of wrapping
          if (kcnt_q != KIJ_LAST) begin
            ptr_d = ptr_q + ONE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          ptr_d = ptr_q + ONE;
        end
      end
      S_LOAD_A: begin
        iaddr_d = cnt_q;
        if (cnt_q == INP_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_IT;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_WAIT_IT: begin
        if (flag_q) begin
          flag_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_CRST;
        end
      end
      S_CRST: begin
        if (cnt_q == ONE) begin
          cnt_d = '0;
          if (kcnt_q == KIJ_LAST) begin
`ifdef KIJ_PSUM_READOUT_EN
            state_d = S_DRAIN;
`else
            state_d = S_DONE;
`endif
          end else begin
            kcnt_d  = kcnt_q + 4'd1;
            state_d = S_LOAD_W;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
`ifdef KIJ_PSUM_READOUT_EN
      S_DRAIN: begin
        prd_d   = 1'b1;
        paddr_d = cnt_q;
        if (cnt_q == INP_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kcnt_q  <= '0;
      ptr_q   <= '0;
      flag_q  <= 1'b0;
      cenw_q  <= 1'b1;
      ceni_q  <= 1'b1;
      wx_q    <= 1'b0;
      waddr_q <= '0;
      iaddr_q <= '0;
      crst_q  <= 1'b0;
      kij_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef KIJ_PSUM_READOUT_EN
      prd_q   <= 1'b0;
      paddr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kcnt_q  <= kcnt_d;
      ptr_q   <= ptr_d;
      flag_q  <= flag_d;
      cenw_q  <= cenw_d;
      ceni_q  <= ceni_d;
      wx_q    <= wx_d;
      waddr_q <= waddr_d;
      iaddr_q <= iaddr_d;
      crst_q  <= crst_d;
      kij_q   <= kij_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef KIJ_PSUM_READOUT_EN
      prd_q   <= prd_d;
      paddr_q <= paddr_d;
`endif
    end
  end

  assign bus.cenw     = cenw_q;
  assign bus.ceni     = ceni_q;
  assign bus.w_x      = wx_q;
  assign bus.Aw       = waddr_q;
  assign bus.Ai       = iaddr_q;
  assign bus.core_rst = crst_q;
  assign bus.kij      = kij_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
`ifdef KIJ_PSUM_READOUT_EN
  assign bus.psum_rd   = prd_q;
  assign bus.psum_addr = paddr_q;
`else
  assign bus.psum_rd   = 1'b0;
  assign bus.psum_addr = '0;
`endif

endmodule

// File: tb/tb_kij_load_scheduler.sv
// Scoreboard bench for kij_load_scheduler: expected address streams
// are queued at start and popped as the DUT emits them.
module tb_kij_load_scheduler;

  localparam int ROW  = 8;
  localparam int NINP = 64;
  localparam int NKIJ = 9;
  localparam int AW   = 11;
  localparam logic [43:0] RST_VEC = {2'b11, 42'd0};

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  kij_load_scheduler_if #(.aw(AW)) bus ();

  kij_load_scheduler dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int q_aw[$];
  int q_ai[$];
  int q_kij[$];
`ifdef KIJ_PSUM_READOUT_EN
  int q_ps[$];
`endif

  int la_cnt = 0;
  int done_cnt = 0;
  int crst_cnt = 0;
  int psum_cyc = 0;
  int last_aw = -1;
  int gap = 0;
  bit gap_on = 0;
  int crst_len = 0;
  int done_len = 0;
  logic p_cenw = 1'b1;
  logic p_ceni = 1'b1;
  logic p_crst = 1'b0;
  logic p_prd = 1'b0;
  logic [AW-1:0] p_paddr = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] out_vec();
    return {bus.cenw, bus.ceni, bus.w_x, bus.Aw, bus.Ai,
            bus.core_rst, bus.kij, bus.psum_rd,
            bus.psum_addr, bus.busy, bus.done};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      crst_len = 0;
      done_len = 0;
      gap_on   = 0;
      p_cenw   = 1'b1;
      p_ceni   = 1'b1;
      p_crst   = 1'b0;
      p_prd    = 1'b0;
    end else begin
      if (!bus.cenw) begin
        if (p_cenw) begin
          if (q_kij.size() == 0) check("kij_unexp", bus.cenw, 1);
          else check("kij", bus.kij, q_kij.pop_front());
        end
        if (q_aw.size() == 0) check("aw_unexp", bus.cenw, 1);
        else check("aw", bus.Aw, q_aw.pop_front());
        last_aw = int'(bus.Aw);
        check("wx_w", bus.w_x, 1);
      end
      if (!bus.ceni) begin
        if (q_ai.size() == 0) check("ai_unexp", bus.ceni, 1);
        else check("ai", bus.Ai, q_ai.pop_front());
        check("wx_a", {bus.w_x, bus.cenw}, 2'b01);
      end
      if (!p_ceni && bus.ceni) begin
        la_cnt++;
        gap_on = 1;
        gap = 0;
      end
      if (gap_on) begin
        if (bus.core_rst) gap_on = 0;
        else gap++;
      end
      if (bus.core_rst) begin
        crst_len++;
      end else if (crst_len != 0) begin
        check("crst_len", crst_len, 2);
        crst_cnt++;
        crst_len = 0;
      end
      if (bus.psum_rd) begin
        psum_cyc++;
`ifdef KIJ_PSUM_READOUT_EN
        if (q_ps.size() == 0) check("ps_unexp", bus.psum_rd, 0);
        else check("psum_addr", bus.psum_addr, q_ps.pop_front());
`endif
      end
      if (bus.done) begin
        if (done_len == 0) begin
          done_cnt++;
`ifdef KIJ_PSUM_READOUT_EN
          check("done_pos", {p_prd, p_paddr}, {1'b1, AW'(NINP - 1)});
`else
          check("done_pos", p_crst, 1);
`endif
        end
        done_len++;
      end else if (done_len != 0) begin
        check("done_len", done_len, 1);
        done_len = 0;
      end
      p_cenw  = bus.cenw;
      p_ceni  = bus.ceni;
      p_crst  = bus.core_rst;
      p_prd   = bus.psum_rd;
      p_paddr = bus.psum_addr;
    end
  end

  task automatic push_exp();
    for (int k = 0; k < NKIJ; k++) begin
      q_kij.push_back(k);
      for (int r = 0; r < ROW; r++) q_aw.push_back(k * ROW + r);
      for (int i = 0; i < NINP; i++) q_ai.push_back(i);
    end
`ifdef KIJ_PSUM_READOUT_EN
    for (int i = 0; i < NINP; i++) q_ps.push_back(i);
`endif
  endtask

  task automatic flush_exp();
    q_aw.delete();
    q_ai.delete();
    q_kij.delete();
`ifdef KIJ_PSUM_READOUT_EN
    q_ps.delete();
`endif
  endtask

  task automatic pulse_iter();
    bus.iter_done = 1'b1;
    @(negedge clk);
    bus.iter_done = 1'b0;
  endtask

  task automatic wait_la(input int target);
    int n = 0;
    while (la_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("la_timeout", la_cnt >= target, 1);
  endtask

  task automatic wait_ai(input int k, input int a);
    int n = 0;
    while (!(!bus.ceni && bus.Ai == AW'(a) && bus.kij == 4'(k))
           && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ai_timeout", n < 400, 1);
  endtask

  task automatic wait_crst();
    int n = 0;
    while (!bus.core_rst && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("crst_timeout", bus.core_rst, 1);
  endtask

  task automatic drive_iters(input int la0, input int nk,
                             input int early);
    for (int k = 0; k < nk; k++) begin
      if (k == early) begin
        wait_ai(k, 20);
        pulse_iter();
        wait_la(la0 + k + 1);
        wait_crst();
        check("wait_it_len", gap, 1);
        check("kij_early", bus.kij, k);
      end else begin
        wait_la(la0 + k + 1);
        repeat (5) @(negedge clk);
        pulse_iter();
      end
    end
  endtask

  task automatic kick();
    bus.start = 1'b1;
    @(negedge clk);
    check("start_lat1", bus.cenw, 1);
  endtask

  task automatic do_run(input int early, input bit hold);
    int la0 = la_cnt;
    int d0 = done_cnt;
    int c0 = crst_cnt;
    int n = 0;
    push_exp();
    kick();
    if (!hold) bus.start = 1'b0;
    @(negedge clk);
    check("start_lat2", {bus.cenw, bus.Aw}, 0);
    drive_iters(la0, NKIJ, early);
    while (!bus.done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", bus.done, 1);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_cnt", done_cnt - d0, 1);
    check("crst_cnt", crst_cnt - c0, NKIJ);
    check("aw_last", last_aw, NKIJ * ROW - 1);
    check("aw_left", q_aw.size(), 0);
    check("ai_left", q_ai.size(), 0);
    check("kij_left", q_kij.size(), 0);
`ifdef KIJ_PSUM_READOUT_EN
    check("ps_left", q_ps.size(), 0);
`else
    check("psum_rd_cyc", psum_cyc, 0);
`endif
    check("idle_after", out_vec(), RST_VEC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int la0;
    int d0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.iter_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vec", out_vec(), RST_VEC);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_vec", out_vec(), RST_VEC);
    end

    do_run(-1, 1'b0);
    do_run(3, 1'b0);

    d0 = done_cnt;
    do_run(-1, 1'b1);
    repeat (6) @(negedge clk);
    check("no_rerun_busy", bus.busy, 0);
    check("no_rerun_done", done_cnt - d0, 1);

    la0 = la_cnt;
    push_exp();
    kick();
    bus.start = 1'b0;
    drive_iters(la0, 5, -1);
    wait_ai(5, 30);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 check("rst_async", out_vec(), RST_VEC);
    flush_exp();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle", out_vec(), RST_VEC);

    do_run(-1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/kij_load_scheduler.md
# kij_load_scheduler

Sequences one full 3x3 quantized convolution through the systolic core. For each of the `kij_len` kernel positions it streams one weight tile from weight SRAM into L0 and then every input activation vector from activation SRAM into L0. It waits for the array's `iter_done`, pulses the core reset, and advances to the next position. After the last position it optionally drives the psum-memory readout. It replaces the hand-sequenced SRAM address, enable and `w_x` control with a synthesizable FSM sitting beside `controller`.

## Interface
- `row`, 8, array rows; number of weight SRAM words per kij tile
- `col`, 8, array columns; informational only, no logic depends on it
- `num_inp`, 64, activation vectors per kij; also the number of psum rows read out
- `kij_len`, 9, kernel positions per convolution
- `aw`, 11, SRAM address width
- `clk` input 1: single clock; all state updates on its rising edge
- `reset` input 1: asynchronous, active-low (0 = reset)
- `start` input 1: run request, sampled only in IDLE
- `iter_done` input 1: from `controller`; MAC iteration for current kij finished
- `cenw` output 1: weight SRAM chip enable, active-low
- `ceni` output 1: activation SRAM chip enable, active-low
- `w_x` output 1: L0 source select (1 = weight SRAM, 0 = activation SRAM)
- `Aw` output aw: weight SRAM address
- `Ai` output aw: activation SRAM address
- `core_rst` output 1: active-high reset pulse to core/`controller` between iterations
- `kij` output 4: current kernel position, 0..kij_len-1
- `psum_rd` output 1: psum memory read enable
- `psum_addr` output aw: psum read row
- `busy` output 1: high in any state other than IDLE
- `done` output 1: one-cycle pulse at end of run

## Operation
- States: IDLE, LOAD_W, LOAD_A, WAIT_IT, CRST, DRAIN, DONE.
- IDLE:
  - `start`=1 → LOAD_W.
  - Clear `kij`, `Ai`, `psum_addr` and the iter flag.
  - Set `Aw`=0.
- LOAD_W:
  - `cenw`=0, `w_x`=1.
  - `Aw` steps kij*row .. kij*row+row-1, one address per cycle, `row` cycles total.
  - `Aw` is never reset between kij positions; weights are stored contiguously.
  - Then → LOAD_A.
- LOAD_A:
  - `cenw`=1, `ceni`=0, `w_x`=0.
  - `Ai` steps 0..num_inp-1, one address per cycle.
  - Then `ceni`=1, `Ai`=0, → WAIT_IT.
  - Activations are reused every kij.
- WAIT_IT: hold until the sticky iter flag is set, then → CRST.
  - The iter flag sets on `iter_done`=1 in any of LOAD_W, LOAD_A or WAIT_IT.
  - An early `iter_done` is therefore never lost.
  - The flag clears on entry to CRST.
- CRST:
  - `core_rst`=1 for exactly 2 cycles.
  - Then `kij`++.
  - If the new `kij` equals `kij_len` → DRAIN, or → DONE when DRAIN is compiled out.
  - Otherwise → LOAD_W.
- DRAIN: `psum_rd`=1, `psum_addr` steps 0..num_inp-1, then → DONE.
- DONE: `done`=1 for one cycle, then → IDLE.
- `start` outside IDLE is ignored.
- `iter_done` in IDLE, CRST or DRAIN is ignored.
- Counters wrap only by explicit clear; no modular overflow is permitted.
- Required: kij_len*row ≤ 2^aw.

## Timing
- Reset values: `cenw`=1, `ceni`=1, `w_x`=0, `Aw`=0, `Ai`=0, `core_rst`=0, `kij`=0, `psum_rd`=0, `psum_addr`=0, `busy`=0, `done`=0, state IDLE.
- All outputs are registered.
- `start` high at edge N → `cenw`=0 with `Aw`=0 visible after edge N+1.
- Per kij cycle count: row + num_inp + W + 2, where W = WAIT_IT cycles (≥1).
- If `iter_done` arrives during LOAD_A, WAIT_IT lasts 1 cycle.
- DRAIN lasts num_inp cycles. `done` asserts the cycle after the last `psum_addr`.
- Reset asserted mid-run: immediately forces the reset values. No `done` is produced, and a fresh `start` is required.

## Configuration
- `KIJ_PSUM_READOUT_EN` defined:
  - DRAIN state is present.
  - `psum_rd`/`psum_addr` are driven as specified.
- `KIJ_PSUM_READOUT_EN` undefined:
  - DRAIN is removed; CRST of the last kij goes directly to DONE.
  - `psum_rd` and `psum_addr` are tied to 0.

## Test plan
- Reset then idle: `reset`=0 for 2 cycles, `start`=0 → all outputs hold reset values for 20 cycles; `busy`=0.
- Single full run (defaults, `iter_done` pulsed 5 cycles after each LOAD_A ends):
  - `Aw` reaches 71 in the last LOAD_W.
  - Exactly 9 LOAD_A bursts of 64 addresses, each with `Ai` 0..63.
  - 9 two-cycle `core_rst` pulses.
  - DRAIN `psum_addr` 0..63.
  - One `done` pulse.
- Early `iter_done`: pulse during LOAD_A of kij=3 → WAIT_IT lasts 1 cycle, `kij` advances to 4, no hang.
- `start` held high throughout the run → exactly one run and one `done`; a new run begins only from IDLE.
- Reset asserted at kij=5 mid-LOAD_A → outputs return to reset values asynchronously; next `start` restarts at `kij`=0, `Aw`=0.
- `KIJ_PSUM_READOUT_EN` undefined: full run → `psum_rd` never 1; `done` 1 cycle after the last CRST cycle.
